glitch_sweep_ctrl: RTL and testbench

Sequencer that runs automated glitch-parameter sweeps through the existing glitch chain. It steps the delay and glitch-pulse lengths over configured ranges and fires one glitch attempt per parameter pair. After each attempt it samples the target GPIOs and hands one result byte per attempt to the UART transmit path. It sits between the command decoder (configuration, start/abort) and the trigger/delay/pulse datapath.

---
 rtl/glitch_sweep_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_glitch_sweep_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/glitch_sweep_ctrl.sv
// Glitch-parameter sweep sequencer: steps pulse (inner) and delay (outer) ranges,
// fires one attempt per pair and hands one sampled gpio byte per attempt to the UART path.
module glitch_sweep_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] delay_min,
  input  logic [WIDTH-1:0] delay_max,
  input  logic [WIDTH-1:0] delay_step,
  input  logic [WIDTH-1:0] pulse_min,
  input  logic [WIDTH-1:0] pulse_max,
  input  logic [WIDTH-1:0] pulse_step,
  input  logic [WIDTH-1:0] settle,
  input  logic [WIDTH-1:0] timeout,
  input  logic [7:0]       gpio,
  input  logic             fire_done,
  output logic [WIDTH-1:0] glitch_delay,
  output logic [WIDTH-1:0] glitch_pulse,
  output logic             fire,
  output logic [7:0]       result_data,
  output logic             result_timeout,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FIRE      = 3'd1,
    ST_WAIT_DONE = 3'd2,
    ST_SETTLE    = 3'd3,
    ST_REPORT    = 3'd4,
    ST_STEP      = 3'd5
  } state_t;

  state_t           state_r, state_s;
  logic [WIDTH-1:0] delay_max_r, delay_step_r;
  logic [WIDTH-1:0] pulse_min_r, pulse_max_r, pulse_step_r;
  logic [WIDTH-1:0] settle_r, timeout_r;
  logic [WIDTH-1:0] glitch_delay_r, glitch_delay_s;
  logic [WIDTH-1:0] glitch_pulse_r, glitch_pulse_s;
  logic [WIDTH-1:0] cnt_r, cnt_s, cnt_inc_s;
  logic [WIDTH:0]   pulse_adv_s, delay_adv_s;
  logic [7:0]       result_data_r, result_data_s;
  logic             fire_r, fire_s;
  logic             result_timeout_r, result_timeout_s;
  logic             result_valid_r, result_valid_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;

  // Returns {ok, next}; ok only when the step is nonzero and the sum neither carries nor passes lim.
  function automatic logic [WIDTH:0] axis_step(input logic [WIDTH-1:0] cur,
                                               input logic [WIDTH-1:0] step,
                                               input logic [WIDTH-1:0] lim);
    logic [WIDTH:0] sum;
    sum = {1'b0, cur} + {1'b0, step};
    if ((step != {WIDTH{1'b0}}) && !sum[WIDTH] && (sum[WIDTH-1:0] <= lim)) begin
      axis_step = {1'b1, sum[WIDTH-1:0]};
    end else begin
      axis_step = {1'b0, cur};
    end
  endfunction

  // Sweep configuration snapshot taken on an accepted start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      delay_max_r  <= {WIDTH{1'b0}};
      delay_step_r <= {WIDTH{1'b0}};
      pulse_min_r  <= {WIDTH{1'b0}};
      pulse_max_r  <= {WIDTH{1'b0}};
      pulse_step_r <= {WIDTH{1'b0}};
      settle_r     <= {WIDTH{1'b0}};
      timeout_r    <= {WIDTH{1'b0}};
    end else if ((state_r == ST_IDLE) && start) begin
      delay_max_r  <= delay_max;
      delay_step_r <= delay_step;
      pulse_min_r  <= pulse_min;
      pulse_max_r  <= pulse_max;
      pulse_step_r <= pulse_step;
      settle_r     <= settle;
      timeout_r    <= timeout;
    end
  end

  // Next-state and next-output logic; abort overrides every non-idle transition.
  always_comb begin
    state_s          = state_r;
    glitch_delay_s   = glitch_delay_r;
    glitch_pulse_s   = glitch_pulse_r;
    cnt_s            = cnt_r;
    result_data_s    = result_data_r;
    result_timeout_s = result_timeout_r;
    result_valid_s   = result_valid_r;
    fire_s           = 1'b0;
    done_s           = 1'b0;
    cnt_inc_s        = cnt_r + {{(WIDTH-1){1'b0}}, 1'b1};
    pulse_adv_s      = axis_step(glitch_pulse_r, pulse_step_r, pulse_max_r);
    delay_adv_s      = axis_step(glitch_delay_r, delay_step_r, delay_max_r);
    if (abort && (state_r != ST_IDLE)) begin
      state_s        = ST_IDLE;
      result_valid_s = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            if ((delay_min > delay_max) || (pulse_min > pulse_max)) begin
              done_s = 1'b1;
            end else begin
              glitch_delay_s = delay_min;
              glitch_pulse_s = pulse_min;
              state_s        = ST_FIRE;
            end
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_FIRE: begin
          fire_s  = 1'b1;
          cnt_s   = {WIDTH{1'b0}};
          state_s = ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          if (fire_done) begin
            result_timeout_s = 1'b0;
            cnt_s            = {WIDTH{1'b0}};
            state_s          = ST_SETTLE;
          end else if ((timeout_r != {WIDTH{1'b0}}) && (cnt_inc_s == timeout_r)) begin
            result_timeout_s = 1'b1;
            cnt_s            = {WIDTH{1'b0}};
            state_s          = ST_SETTLE;
          end else begin
            cnt_s = cnt_inc_s;
          end
        end
        ST_SETTLE: begin
          if (cnt_r == settle_r) begin
            result_data_s  = gpio;
            result_valid_s = 1'b1;
            state_s        = ST_REPORT;
          end else begin
            cnt_s = cnt_inc_s;
          end
        end
        ST_REPORT: begin
          if (result_ready) begin
            result_valid_s = 1'b0;
            state_s        = ST_STEP;
          end else begin
            state_s = ST_REPORT;
          end
        end
        ST_STEP: begin
          if (pulse_adv_s[WIDTH]) begin
            glitch_pulse_s = pulse_adv_s[WIDTH-1:0];
            state_s        = ST_FIRE;
          end else begin
            glitch_pulse_s = pulse_min_r;
            if (delay_adv_s[WIDTH]) begin
              glitch_delay_s = delay_adv_s[WIDTH-1:0];
              state_s        = ST_FIRE;
            end else begin
              done_s  = 1'b1;
              state_s = ST_IDLE;
            end
          end
        end
        default: begin
          result_valid_s = 1'b0;
          state_s        = ST_IDLE;
        end
      endcase
    end
    busy_s = (state_s != ST_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r          <= ST_IDLE;
      glitch_delay_r   <= {WIDTH{1'b0}};
      glitch_pulse_r   <= {WIDTH{1'b0}};
      cnt_r            <= {WIDTH{1'b0}};
      result_data_r    <= 8'h00;
      result_timeout_r <= 1'b0;
      result_valid_r   <= 1'b0;
      fire_r           <= 1'b0;
      busy_r           <= 1'b0;
      done_r           <= 1'b0;
    end else begin
      state_r          <= state_s;
      glitch_delay_r   <= glitch_delay_s;
      glitch_pulse_r   <= glitch_pulse_s;
      cnt_r            <= cnt_s;
      result_data_r    <= result_data_s;
      result_timeout_r <= result_timeout_s;
      result_valid_r   <= result_valid_s;
      fire_r           <= fire_s;
      busy_r           <= busy_s;
      done_r           <= done_s;
    end
  end

  assign glitch_delay   = glitch_delay_r;
  assign glitch_pulse   = glitch_pulse_r;
  assign fire           = fire_r;
  assign result_data    = result_data_r;
  assign result_timeout = result_timeout_r;
  assign result_valid   = result_valid_r;
  assign busy           = busy_r;
  assign done           = done_r;

endmodule

// File: tb/tb_glitch_sweep_ctrl.sv
// Self-checking bench for glitch_sweep_ctrl: directed sweeps plus randomized ones,
// each compared against an attempt list and latency model derived from the sweep rules.
module tb_glitch_sweep_ctrl;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, start, abort, fire_done, result_ready;
  logic [W-1:0] delay_min, delay_max, delay_step, pulse_min, pulse_max, pulse_step;
  logic [W-1:0] settle, timeout;
  logic [7:0]   gpio;
  logic [W-1:0] glitch_delay, glitch_pulse;
  logic         fire, result_timeout, result_valid, busy, done;
  logic [7:0]   result_data;

  int n_assert = 0;
  int n_fail   = 0;

  glitch_sweep_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .delay_min(delay_min), .delay_max(delay_max), .delay_step(delay_step),
    .pulse_min(pulse_min), .pulse_max(pulse_max), .pulse_step(pulse_step),
    .settle(settle), .timeout(timeout), .gpio(gpio), .fire_done(fire_done),
    .glitch_delay(glitch_delay), .glitch_pulse(glitch_pulse), .fire(fire),
    .result_data(result_data), .result_timeout(result_timeout),
    .result_valid(result_valid), .result_ready(result_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_delay"}, glitch_delay, 0);
    check({tag, "_pulse"}, glitch_pulse, 0);
    check({tag, "_fire"}, fire, 0);
    check({tag, "_data"}, result_data, 0);
    check({tag, "_tmo"}, result_timeout, 0);
    check({tag, "_valid"}, result_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask

  task automatic set_cfg(input logic [31:0] dmin, dmax, dstep, pmin, pmax, pstep, st, to);
    delay_min = dmin; delay_max = dmax; delay_step = dstep;
    pulse_min = pmin; pulse_max = pmax; pulse_step = pstep;
    settle = st; timeout = to;
  endtask

  // One complete sweep. fd_lat: cycles from fire to fire_done (<1 = never sent).
  // stall: cycles result_ready stays low after each result appears.
  task automatic run_sweep(input string name, input int fd_lat, input int stall,
                           input bit gpio_fixed, input logic [7:0] gpio_val);
    longint qd[$], qp[$];
    longint dmin, pmin, st, to;
    int     total, fires, dones, since_hs, c_fire, stall_left, exp_lat;
    bit     fin, prev_valid, exp_to;
    logic [7:0] cap_data;
    logic       cap_to;
    dmin = delay_min; pmin = pulse_min; st = settle; to = timeout;
    for (longint d = delay_min; d <= longint'(delay_max); d += delay_step) begin
      for (longint p = pulse_min; p <= longint'(pulse_max); p += pulse_step) begin
        qd.push_back(d); qp.push_back(p);
        if (pulse_step == 0) break;
      end
      if (delay_step == 0) break;
    end
    total = qd.size();
    fires = 0; dones = 0; fin = 1'b0; prev_valid = 1'b0;
    since_hs = 100000; c_fire = 100000; stall_left = 0; cap_data = 8'h00; cap_to = 1'b0;
    gpio = gpio_fixed ? gpio_val : 8'($urandom);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int cyc = 0; cyc < 20000 && !fin; cyc++) begin
      if (cyc > 0) @(negedge clk);
      since_hs++; c_fire++;
      if (cyc == 0 && total > 0) begin
        check({name, "_start_delay"}, glitch_delay, dmin);
        check({name, "_start_pulse"}, glitch_pulse, pmin);
        check({name, "_start_busy"}, busy, 1);
        check({name, "_start_nofire"}, fire, 0);
      end
      if (fire) begin
        if (fires == 0) check({name, "_fire_lat_start"}, cyc, 1);
        else            check({name, "_fire_lat_hs"}, since_hs, 2);
        if (qd.size() == 0) begin
          check({name, "_fire_extra"}, 1, 0);
        end else begin
          check({name, "_fire_delay"}, glitch_delay, qd.pop_front());
          check({name, "_fire_pulse"}, glitch_pulse, qp.pop_front());
        end
        fires++; c_fire = 0;
      end
      if (result_valid && !prev_valid) begin
        exp_to  = (fd_lat < 1) || (to != 0 && fd_lat > to);
        exp_lat = exp_to ? int'(to + 1 + st) : int'(fd_lat + 1 + st);
        check({name, "_res_lat"}, c_fire, exp_lat);
        check({name, "_res_data"}, result_data, gpio);
        check({name, "_res_tmo"}, result_timeout, exp_to);
        cap_data = result_data; cap_to = result_timeout; stall_left = stall;
      end else if (result_valid && prev_valid) begin
        check({name, "_hold_data"}, result_data, cap_data);
        check({name, "_hold_tmo"}, result_timeout, cap_to);
      end else if (!result_valid && prev_valid) begin
        check({name, "_valid_fall"}, since_hs, 0);
      end
      if (done) begin
        dones++; fin = 1'b1;
        check({name, "_done_busy"}, busy, 0);
        check({name, "_done_fires"}, fires, total);
        if (total == 0) check({name, "_done_lat_start"}, cyc, 0);
        else            check({name, "_done_lat_hs"}, since_hs, 1);
      end
      prev_valid = result_valid;
      if (result_valid && stall_left == 0) begin
        result_ready = 1'b1; since_hs = -1;
      end else begin
        result_ready = 1'b0;
        if (result_valid) stall_left--;
      end
      fire_done = (c_fire == fd_lat - 1);
      gpio = gpio_fixed ? gpio_val : 8'($urandom);
      // Scramble configuration inputs; the running sweep must ignore them.
      set_cfg($urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
    end
    if (!fin) check({name, "_sweep_timeout"}, 0, 1);
    result_ready = 1'b0; fire_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check({name, "_idle_done"}, done, 0);
      check({name, "_idle_fire"}, fire, 0);
      check({name, "_idle_busy"}, busy, 0);
    end
    check({name, "_done_count"}, dones, 1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; fire_done = 1'b0;
    result_ready = 1'b0; gpio = 8'h00;
    set_cfg(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    check_outputs_zero("reset");
    reset = 1'b0;

    set_cfg(10, 30, 10, 2, 3, 1, 4, 100);
    run_sweep("basic", 5, 0, 1'b0, 8'h00);
    set_cfg(1, 1, 0, 7, 8, 1, 3, 50);
    run_sweep("tmo", -1, 0, 1'b1, 8'hA5);
    set_cfg(4, 4, 0, 1, 2, 1, 2, 0);
    run_sweep("stall", 3, 20, 1'b0, 8'h00);
    set_cfg(32'hFFFF_FFFE, 32'hFFFF_FFFF, 2, 3, 3, 0, 1, 0);
    run_sweep("wrap", 2, 1, 1'b0, 8'h00);
    set_cfg(0, 9, 1, 5, 4, 1, 0, 0);
    run_sweep("empty", 1, 0, 1'b0, 8'h00);
    set_cfg(7, 3, 1, 0, 0, 0, 0, 0);
    run_sweep("empty_d", 1, 0, 1'b0, 8'h00);

    // Abort while waiting for fire_done; a late fire_done must be ignored.
    set_cfg(100, 100, 0, 7, 7, 0, 0, 0);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    check("abort_fire", fire, 1);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_fire_off", fire, 0);
    fire_done = 1'b1;
    @(negedge clk); fire_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("abort_late_busy", busy, 0);
      check("abort_late_valid", result_valid, 0);
      check("abort_late_done", done, 0);
      check("abort_late_fire", fire, 0);
    end

    // Asynchronous reset while in SETTLE, then a fresh sweep.
    set_cfg(5, 5, 0, 9, 9, 0, 10, 0);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    check("rst_fire", fire, 1);
    fire_done = 1'b1;
    @(negedge clk); fire_done = 1'b0;
    @(negedge clk);
    check("rst_pre_busy", busy, 1);
    #2 reset = 1'b1;
    #1 check_outputs_zero("async_rst");
    @(negedge clk);
    check_outputs_zero("rst_hold");
    reset = 1'b0;
    set_cfg(40, 50, 10, 1, 2, 1, 2, 0);
    run_sweep("post_rst", 3, 1, 1'b0, 8'h00);

    for (int t = 0; t < 3; t++) begin
      logic [31:0] dmn, pmn, tmo;
      int          fdl;
      dmn = $urandom_range(0, 30);
      pmn = $urandom_range(0, 30);
      tmo = ($urandom_range(0, 1) == 1) ? $urandom_range(3, 10) : 0;
      fdl = (tmo != 0 && $urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(1, 12));
      set_cfg(dmn, dmn + $urandom_range(0, 12), $urandom_range(0, 6),
              pmn, pmn + $urandom_range(0, 12), $urandom_range(0, 6),
              $urandom_range(0, 5), tmo);
      run_sweep($sformatf("rand%0d", t), fdl, int'($urandom_range(0, 3)), 1'b0, 8'h00);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
